// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: cause codes,
// FSM state encoding and the CSR addresses also used by the CSR file.
package trap_ctrl_pkg;

    localparam logic [31:0] CAUSE_ILLEGAL   = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK    = 32'd3;
    localparam logic [31:0] CAUSE_ECALL     = 32'd11;
    localparam logic [31:0] CAUSE_TIMER_DEF = 32'h8000_0007;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SAVE  = 3'd1,
        ST_TVEC  = 3'd2,
        ST_RET   = 3'd3,
        ST_REDIR = 3'd4
    } trap_state_e;

endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// Combinational priority encoder for trap sources: timer interrupt, then
// illegal, ecall, ebreak, and finally mret (a return, not a trap).
module trap_prio_enc
    import trap_ctrl_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] CAUSE_TIMER = XLEN'(CAUSE_TIMER_DEF)
) (
    input  logic            inst_valid,
    input  logic            irq_take,
    input  logic            is_illegal,
    input  logic            is_ecall,
    input  logic            is_ebreak,
    input  logic            is_mret,
    output logic            take,
    output logic            is_ret,
    output logic [XLEN-1:0] cause
);

    // Pick the highest-priority source of the presented instruction
    always_comb begin
        take   = 1'b0;
        is_ret = 1'b0;
        cause  = '0;
        if (inst_valid) begin
            if (irq_take) begin
                take  = 1'b1;
                cause = CAUSE_TIMER;
            end else if (is_illegal) begin
                take  = 1'b1;
                cause = XLEN'(CAUSE_ILLEGAL);
            end else if (is_ecall) begin
                take  = 1'b1;
                cause = XLEN'(CAUSE_ECALL);
            end else if (is_ebreak) begin
                take  = 1'b1;
                cause = XLEN'(CAUSE_EBREAK);
            end else if (is_mret) begin
                is_ret = 1'b1;
            end else begin
                take = 1'b0;
            end
        end else begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / mret sequencer with a registered fetch redirect.
// Optional TRAP_CTRL_VECTORED_EN: vectored mtvec for asynchronous causes.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] CAUSE_TIMER = XLEN'(CAUSE_TIMER_DEF)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid,
    input  logic [XLEN-1:0] inst_pc,
    input  logic            is_illegal,
    input  logic            is_ecall,
    input  logic            is_ebreak,
    input  logic            is_mret,
    input  logic            timer_irq,
    input  logic            mstatus_mie,
    input  logic [XLEN-1:0] mtvec_rdata,
    input  logic [XLEN-1:0] mepc_rdata,
    output logic            trap_ready,
    output logic            flush,
    output logic            exception_en,
    output logic [XLEN-1:0] mepc_wdata,
    output logic [XLEN-1:0] mcause_wdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready
);

    trap_state_e     state_q, state_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] rpc_q, rpc_d;

    logic            irq_take_s;
    logic            take_s;
    logic            is_ret_s;
    logic [XLEN-1:0] cause_s;
    logic            accept_s;
    logic [XLEN-1:0] tvec_base_s;
    logic [XLEN-1:0] tvec_target_s;

    assign irq_take_s = timer_irq & mstatus_mie;

    trap_prio_enc #(
        .XLEN        (XLEN),
        .CAUSE_TIMER (CAUSE_TIMER)
    ) u_prio (
        .inst_valid (inst_valid),
        .irq_take   (irq_take_s),
        .is_illegal (is_illegal),
        .is_ecall   (is_ecall),
        .is_ebreak  (is_ebreak),
        .is_mret    (is_mret),
        .take       (take_s),
        .is_ret     (is_ret_s),
        .cause      (cause_s)
    );

    assign accept_s    = (state_q == ST_IDLE) & (take_s | is_ret_s);
    assign tvec_base_s = mtvec_rdata & ~XLEN'(3);

    // Trap vector target from the latched cause; sampled in TVEC after the CSR write
    always_comb begin
        tvec_target_s = tvec_base_s;
`ifdef TRAP_CTRL_VECTORED_EN
        if ((mtvec_rdata[1:0] == 2'b01) && mcause_q[XLEN-1]) begin
            tvec_target_s = tvec_base_s + ({1'b0, mcause_q[XLEN-2:0]} << 2);
        end else begin
            tvec_target_s = tvec_base_s;
        end
`endif
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mepc_q   <= '0;
            mcause_q <= '0;
            rpc_q    <= '0;
        end else begin
            state_q  <= state_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            rpc_q    <= rpc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && take_s) begin
                    state_d = ST_SAVE;
                end else if (accept_s && is_ret_s) begin
                    state_d = ST_RET;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAVE:  state_d = ST_TVEC;
            ST_TVEC:  state_d = ST_REDIR;
            ST_RET:   state_d = ST_REDIR;
            ST_REDIR: begin
                if (redirect_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REDIR;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Latch trap info on accept and the redirect target in TVEC/RET
    always_comb begin
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        rpc_d    = rpc_q;
        if (accept_s && take_s) begin
            mepc_d   = inst_pc;
            mcause_d = cause_s;
        end else begin
            mepc_d   = mepc_q;
            mcause_d = mcause_q;
        end
        case (state_q)
            ST_TVEC: rpc_d = tvec_target_s;
            ST_RET:  rpc_d = mepc_rdata;
            default: rpc_d = rpc_q;
        endcase
    end

    // Output decode from registered state
    always_comb begin
        trap_ready     = (state_q == ST_IDLE);
        exception_en   = (state_q == ST_SAVE);
        redirect_valid = (state_q == ST_REDIR);
        flush          = accept_s & ~rst;
        mepc_wdata     = mepc_q;
        mcause_wdata   = mcause_q;
        redirect_pc    = rpc_q;
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized events
// checked against a behavioural model of the trap/mret rules.
module tb_trap_ctrl;

    localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_valid = 1'b0;
    logic [31:0] inst_pc = 32'h0;
    logic        is_illegal = 1'b0, is_ecall = 1'b0, is_ebreak = 1'b0, is_mret = 1'b0;
    logic        timer_irq = 1'b0, mstatus_mie = 1'b0;
    logic [31:0] mtvec_rdata = 32'h0, mepc_rdata = 32'h0;
    logic        trap_ready, flush, exception_en, redirect_valid;
    logic [31:0] mepc_wdata, mcause_wdata, redirect_pc;
    logic        redirect_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_mepc = 32'h0;
    logic [31:0] exp_mcause = 32'h0;
    logic [31:0] seen_pc = 32'h0;

    trap_ctrl #(.XLEN(32), .CAUSE_TIMER(CAUSE_TIMER)) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_pc(inst_pc),
        .is_illegal(is_illegal), .is_ecall(is_ecall), .is_ebreak(is_ebreak), .is_mret(is_mret),
        .timer_irq(timer_irq), .mstatus_mie(mstatus_mie),
        .mtvec_rdata(mtvec_rdata), .mepc_rdata(mepc_rdata),
        .trap_ready(trap_ready), .flush(flush), .exception_en(exception_en),
        .mepc_wdata(mepc_wdata), .mcause_wdata(mcause_wdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready)
    );

    always #5 clk = ~clk;

    task automatic clear_inst();
        inst_valid = 1'b0; is_illegal = 1'b0; is_ecall = 1'b0; is_ebreak = 1'b0; is_mret = 1'b0;
    endtask

    // One event from IDLE through redirect completion, with model-derived expectations.
    task automatic run_event(input logic il, input logic ec, input logic eb, input logic mr,
                             input logic irq, input logic mie, input logic [31:0] pc,
                             input logic [31:0] mtvec, input logic [31:0] mepc,
                             input int wait_cycles, input logic ebreak_during);
        logic exp_trap, exp_ret;
        logic [31:0] cause, target;
        exp_trap = (irq & mie) | il | ec | eb;
        exp_ret  = !exp_trap && mr;
        if (irq & mie)  cause = CAUSE_TIMER;
        else if (il)    cause = 32'd2;
        else if (ec)    cause = 32'd11;
        else if (eb)    cause = 32'd3;
        else            cause = 32'd0;
        if (exp_ret) target = mepc;
        else begin
            target = {mtvec[31:2], 2'b00};
`ifdef TRAP_CTRL_VECTORED_EN
            if (mtvec[1:0] == 2'b01 && cause[31]) target = target + 4 * {1'b0, cause[30:0]};
`endif
        end

        @(negedge clk);
        checks++;
        if (trap_ready !== 1'b1) begin failures++; $display("FAIL ev_idle_ready: got %b expected 1", trap_ready); end
        inst_pc = pc; mtvec_rdata = mtvec; mepc_rdata = mepc; redirect_ready = 1'b0;
        is_illegal = il; is_ecall = ec; is_ebreak = eb; is_mret = mr;
        timer_irq = irq; mstatus_mie = mie; inst_valid = 1'b1;
        #1;
        checks++;
        if (flush !== (exp_trap | exp_ret)) begin failures++; $display("FAIL ev_flush: got %b expected %b", flush, exp_trap | exp_ret); end

        @(negedge clk);
        clear_inst();
        timer_irq = 1'($urandom); mstatus_mie = 1'($urandom);
        #1;
        checks++;
        if (flush !== 1'b0) begin failures++; $display("FAIL ev_flush_once: got %b expected 0", flush); end
        if (!exp_trap && !exp_ret) begin
            checks++;
            if (trap_ready !== 1'b1 || exception_en !== 1'b0 || redirect_valid !== 1'b0) begin
                failures++; $display("FAIL ev_plain_ignored: ready=%b exc=%b rv=%b expected 1 0 0", trap_ready, exception_en, redirect_valid);
            end
            return;
        end
        if (exp_trap) begin
            exp_mepc = pc; exp_mcause = cause;
        end
        checks++;
        if (trap_ready !== 1'b0) begin failures++; $display("FAIL ev_ready_drop: got %b expected 0", trap_ready); end
        checks++;
        if (exception_en !== exp_trap || redirect_valid !== 1'b0) begin
            failures++; $display("FAIL ev_save: exc=%b rv=%b expected %b 0", exception_en, redirect_valid, exp_trap);
        end
        checks++;
        if (mepc_wdata !== exp_mepc || mcause_wdata !== exp_mcause) begin
            failures++; $display("FAIL ev_csr_data: mepc=%h mcause=%h expected %h %h", mepc_wdata, mcause_wdata, exp_mepc, exp_mcause);
        end
        if (exp_trap) begin
            @(negedge clk);
            checks++;
            if (exception_en !== 1'b0 || redirect_valid !== 1'b0) begin
                failures++; $display("FAIL ev_tvec: exc=%b rv=%b expected 0 0", exception_en, redirect_valid);
            end
        end

        @(negedge clk);
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== target || exception_en !== 1'b0) begin
            failures++; $display("FAIL ev_redirect: rv=%b pc=%h exc=%b expected 1 %h 0", redirect_valid, redirect_pc, exception_en, target);
        end
        seen_pc = redirect_pc;
        for (int w = 0; w < wait_cycles; w++) begin
            if (ebreak_during) begin
                inst_valid = 1'b1; is_ebreak = 1'b1; inst_pc = $urandom;
                #1;
                checks++;
                if (flush !== 1'b0) begin failures++; $display("FAIL ev_busy_flush: got %b expected 0", flush); end
            end
            @(negedge clk);
            checks++;
            if (redirect_valid !== 1'b1 || redirect_pc !== target || trap_ready !== 1'b0 || exception_en !== 1'b0) begin
                failures++; $display("FAIL ev_stall: rv=%b pc=%h ready=%b exc=%b expected 1 %h 0 0", redirect_valid, redirect_pc, trap_ready, exception_en, target);
            end
        end
        clear_inst();
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        checks++;
        if (trap_ready !== 1'b1 || redirect_valid !== 1'b0 || exception_en !== 1'b0) begin
            failures++; $display("FAIL ev_done: ready=%b rv=%b exc=%b expected 1 0 0", trap_ready, redirect_valid, exception_en);
        end
        checks++;
        if (mepc_wdata !== exp_mepc || mcause_wdata !== exp_mcause) begin
            failures++; $display("FAIL ev_csr_hold: mepc=%h mcause=%h expected %h %h", mepc_wdata, mcause_wdata, exp_mepc, exp_mcause);
        end
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if (trap_ready !== 1'b1 || flush !== 1'b0 || exception_en !== 1'b0 || redirect_valid !== 1'b0 ||
            mepc_wdata !== 32'h0 || mcause_wdata !== 32'h0 || redirect_pc !== 32'h0) begin
            failures++;
            $display("FAIL %s: ready=%b flush=%b exc=%b rv=%b mepc=%h mcause=%h pc=%h expected 1 0 0 0 0 0 0",
                     name, trap_ready, flush, exception_en, redirect_valid, mepc_wdata, mcause_wdata, redirect_pc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset_state");
        exp_mepc = 32'h0; exp_mcause = 32'h0;
    endtask

    task automatic test_ecall();
        run_event(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0100, 32'h8000_0400, 32'h0, 0, 1'b0);
        checks++;
        if (seen_pc !== 32'h8000_0400) begin failures++; $display("FAIL ecall_target: got %h expected 80000400", seen_pc); end
    endtask

    task automatic test_priority();
        run_event(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0200, 32'h8000_0400, 32'h0, 0, 1'b0);
        checks++;
        if (mcause_wdata !== 32'h8000_0007) begin failures++; $display("FAIL prio_irq: got %h expected 80000007", mcause_wdata); end
        run_event(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8000_0204, 32'h8000_0400, 32'h0, 0, 1'b0);
        checks++;
        if (mcause_wdata !== 32'd2) begin failures++; $display("FAIL prio_illegal: got %h expected 2", mcause_wdata); end
    endtask

    task automatic test_mret();
        run_event(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0300, 32'h8000_0400, 32'h8000_0204, 0, 1'b0);
        checks++;
        if (seen_pc !== 32'h8000_0204) begin failures++; $display("FAIL mret_target: got %h expected 80000204", seen_pc); end
    endtask

    task automatic test_backpressure();
        run_event(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0500, 32'h8000_0800, 32'h0, 5, 1'b1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        inst_pc = 32'h8000_0600; mtvec_rdata = 32'h8000_0400; inst_valid = 1'b1; is_ecall = 1'b1;
        @(negedge clk);
        clear_inst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset_in_save");
        @(negedge clk);
        check_reset_state("reset_in_save_after");
        inst_valid = 1'b1; is_illegal = 1'b1; redirect_ready = 1'b0;
        @(negedge clk);
        clear_inst();
        repeat (2) @(negedge clk);
        checks++;
        if (redirect_valid !== 1'b1) begin failures++; $display("FAIL reach_redir: got %b expected 1", redirect_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset_in_redir");
        exp_mepc = 32'h0; exp_mcause = 32'h0;
    endtask

    task automatic test_vectored();
        run_event(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0700, 32'h8000_0401, 32'h0, 0, 1'b0);
        checks++;
`ifdef TRAP_CTRL_VECTORED_EN
        if (seen_pc !== 32'h8000_041C) begin failures++; $display("FAIL vectored_irq: got %h expected 8000041c", seen_pc); end
`else
        if (seen_pc !== 32'h8000_0400) begin failures++; $display("FAIL vectored_irq: got %h expected 80000400", seen_pc); end
`endif
        run_event(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0704, 32'h8000_0401, 32'h0, 0, 1'b0);
        checks++;
        if (seen_pc !== 32'h8000_0400) begin failures++; $display("FAIL vectored_sync: got %h expected 80000400", seen_pc); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            run_event(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                      1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                      $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_priority();
        test_mret();
        test_backpressure();
        test_reset_mid();
        test_vectored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
